// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and framing constants.
// Used by the receiver today and intended for reuse by the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned MIN_CYCLES_PER_BIT = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Parameterised synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, push_data write request and data (accepted when not full, or when
//                   a pop happens in the same cycle)
//   pop             remove the head entry (ignored when empty)
//   pop_data        head entry; reads as zero while empty
//   full, empty     occupancy flags
//   count           current occupancy, 0..DEPTH
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receive front-end for one channel.
// Synchronises rx, deframes characters at a programmable bit period and
// queues bytes in a FWFT FIFO with sticky frame/overrun error flags.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   enable          receiver enable; low aborts any frame in progress
//   cyclesPerBit    clk cycles per bit (values below 4 act as 4)
//   rx              asynchronous serial input, idle high
//   readStrobe      pop FIFO head (ignored when empty)
//   clearErrors     clear frameError and overrun
//   dataOut         FIFO head byte, valid while dataAvailable
//   dataAvailable   FIFO not empty
//   fifoCount       FIFO occupancy
//   frameError      sticky: stop bit sampled low
//   overrun         sticky: byte dropped because FIFO full
//   busy            frame in progress
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          cyclesPerBit,
    input  logic                          rx,
    input  logic                          readStrobe,
    input  logic                          clearErrors,
    output logic [7:0]                    dataOut,
    output logic                          dataAvailable,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          frameError,
    output logic                          overrun,
    output logic                          busy
);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_d;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cpb_eff;
    logic [DIV_WIDTH-1:0] half;
    logic [DIV_WIDTH-1:0] last;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 stop_sample;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overrun_set;
    logic                 frame_err_set;

    assign cpb_eff = (cyclesPerBit < DIV_WIDTH'(MIN_CYCLES_PER_BIT))
                   ? DIV_WIDTH'(MIN_CYCLES_PER_BIT) : cyclesPerBit;
    assign half    = cpb_eff >> 1;
    assign last    = cpb_eff - DIV_WIDTH'(1);

    // The stop-bit decision is combinational so the FIFO captures the byte
    // on the same edge that ends the frame.
    assign stop_sample   = enable && (state == STOP) && (cnt == last);
    assign push          = stop_sample && rxs;
    assign frame_err_set = stop_sample && !rxs;
    assign overrun_set   = push && fifo_full && !readStrobe;

    assign busy          = (state != IDLE);
    assign dataAvailable = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift),
        .pop       (readStrobe),
        .pop_data  (dataOut),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifoCount)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            frameError <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;

            // Clear first so a simultaneous new error still sets the flag.
            if (clearErrors) begin
                frameError <= 1'b0;
                overrun    <= 1'b0;
            end
            if (frame_err_set) begin
                frameError <= 1'b1;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end

            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (rxs_d && !rxs) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt == half) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + DIV_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == last) begin
                            cnt     <= '0;
                            shift   <= {rxs, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + DIV_WIDTH'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + DIV_WIDTH'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated bit by bit,
// expected bytes are queued at issue time and a monitor compares every pop.
module tb_uart_receiver;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] cyclesPerBit;
    logic          rx;
    logic          readStrobe;
    logic          clearErrors;
    logic [7:0]    dataOut;
    logic          dataAvailable;
    logic [CW-1:0] fifoCount;
    logic          frameError;
    logic          overrun;
    logic          busy;

    uart_receiver #(
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .cyclesPerBit  (cyclesPerBit),
        .rx            (rx),
        .readStrobe    (readStrobe),
        .clearErrors   (clearErrors),
        .dataOut       (dataOut),
        .dataAvailable (dataAvailable),
        .fifoCount     (fifoCount),
        .frameError    (frameError),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    byte unsigned exp_q[$];
    bit          exp_frame_err = 1'b0;
    bit          exp_overrun   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle that pops a non-empty FIFO must present the
    // oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && readStrobe && dataAvailable) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no data", dataOut);
                end else begin
                    check("pop_data", dataOut, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        check({tag, "_count"}, fifoCount, exp_q.size());
        check({tag, "_avail"}, dataAvailable, exp_q.size() != 0);
        check({tag, "_ferr"}, frameError, exp_frame_err);
        check({tag, "_ovr"}, overrun, exp_overrun);
        if (exp_q.size() != 0) check({tag, "_head"}, dataOut, exp_q[0]);
        step();
    endtask

    task automatic clear_errors();
        clearErrors = 1'b1;
        step();
        clearErrors = 1'b0;
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        readStrobe = 1'b1;
        while (dataAvailable && n < DEPTH + 4) begin
            step();
            n++;
        end
        readStrobe = 1'b0;
        check("drain_empty", dataAvailable, 1'b0);
    endtask

    // abort_kind: 0 none, 1 drop enable, 2 assert rst, applied in cycle abort_at.
    task automatic send_frame(input byte unsigned data, input bit stop_bit,
                              input int cpb_set, input bit pop_at_stop,
                              input int abort_kind, input int abort_at);
        int  cpb, half, es_c, len, b, n;
        bit  was_empty, accept;
        cpb       = (cpb_set < 4) ? 4 : cpb_set;
        half      = cpb / 2;
        es_c      = 3 + half + 9 * cpb;
        len       = (10 * cpb > es_c + 3) ? 10 * cpb : es_c + 3;
        was_empty = (exp_q.size() == 0);
        accept    = stop_bit && (exp_q.size() < DEPTH || pop_at_stop);
        cyclesPerBit = DW'(cpb_set);
        if (abort_kind == 0 && accept) exp_q.push_back(data);
        for (int c = 0; c < len; c++) begin
            b  = c / cpb;
            rx = (b == 0) ? 1'b0 : (b <= 8) ? data[b-1] : (b == 9) ? stop_bit : 1'b1;
            readStrobe = pop_at_stop && (c == es_c);
            if (abort_kind == 1 && c == abort_at) enable = 1'b0;
            if (abort_kind == 2 && c == abort_at) rst = 1'b1;
            @(negedge clk);
            if (abort_kind == 0 && was_empty && c == es_c)
                check("early_avail", dataAvailable, 1'b0);
            if (abort_kind == 0 && was_empty && c == es_c + 1)
                check("latency_avail", dataAvailable, accept);
            if (abort_kind != 0 && c == abort_at + 1) begin
                check("abort_busy", busy, 1'b0);
                if (abort_kind == 2) begin
                    exp_q.delete();
                    exp_frame_err = 1'b0;
                    exp_overrun   = 1'b0;
                    check("rst_data", dataOut, 8'h00);
                end
                check("abort_count", fifoCount, exp_q.size());
                check("abort_ferr", frameError, exp_frame_err);
                check("abort_ovr", overrun, exp_overrun);
                step();
                break;
            end
            step();
        end
        rx = 1'b1;
        readStrobe = 1'b0;
        if (abort_kind == 1) begin
            idle(3);
            enable = 1'b1;
        end
        if (abort_kind == 2) rst = 1'b0;
        if (abort_kind == 0) begin
            if (!stop_bit) exp_frame_err = 1'b1;
            else if (!accept) exp_overrun = 1'b1;
        end
        n = 0;
        while (busy && n < 4 * cpb + 8) begin
            step();
            n++;
        end
        check("frame_end_idle", busy, 1'b0);
        idle(2);
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; rx = 1'b1; readStrobe = 1'b0;
        clearErrors = 1'b0; cyclesPerBit = DW'(16);
        idle(3);
        @(negedge clk);
        check("rst_data", dataOut, 8'h00);
        check("rst_avail", dataAvailable, 1'b0);
        check("rst_count", fifoCount, 0);
        check("rst_ferr", frameError, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        rst = 1'b0; enable = 1'b1;
        idle(3);

        // Basic frame at 16 cycles/bit
        send_frame(8'hA5, 1'b1, 16, 1'b0, 0, 0);
        check_status("a5");
        drain();

        // False start: short low glitch at 8 cycles/bit
        cyclesPerBit = DW'(8);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        n = 0;
        while (busy == 1'b0 && n < 4) begin step(); n++; end
        check("glitch_seen", busy, 1'b1);
        n = 0;
        while (busy && n < 8) begin step(); n++; end
        check("glitch_idle", busy, 1'b0);
        check_status("glitch");

        // Frame error, clear, then break
        send_frame(8'h3C, 1'b0, 10, 1'b0, 0, 0);
        check_status("ferr");
        clear_errors();
        check_status("ferr_clr");
        rx = 1'b0;
        idle(50 * 10);
        exp_frame_err = 1'b1;
        check_status("break");
        clear_errors();
        idle(100);
        check_status("break_clr");
        check("break_busy", busy, 1'b0);
        rx = 1'b1;
        idle(4);

        // Overrun at minimum bit period
        for (int i = 0; i <= DEPTH; i++) send_frame(byte'(i), 1'b1, 4, 1'b0, 0, 0);
        check_status("ovr");
        drain();
        clear_errors();
        for (int i = 0; i < DEPTH; i++) send_frame(byte'($urandom_range(0, 255)), 1'b1, 4, 1'b0, 0, 0);
        send_frame(8'h55, 1'b1, 4, 1'b1, 0, 0);
        check_status("full_pushpop");
        drain();

        // Clamped divider and enable abort mid-DATA
        send_frame(8'h81, 1'b1, 2, 1'b0, 0, 0);
        check_status("clamp");
        send_frame(8'h3E, 1'b1, 4, 1'b0, 0, 0);
        send_frame(8'h77, 1'b1, 2, 1'b0, 1, 4 * 4);
        check_status("en_abort");
        drain();

        // Reset mid-frame with bytes queued, then recovery
        send_frame(8'hC3, 1'b1, 4, 1'b0, 0, 0);
        send_frame(8'h5A, 1'b1, 4, 1'b0, 0, 0);
        send_frame(8'hF0, 1'b1, 4, 1'b0, 2, 5 * 4 + 1);
        check_status("rst_mid");
        send_frame(8'h12, 1'b1, 4, 1'b0, 0, 0);
        check_status("after_rst");
        drain();

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            send_frame(byte'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                       int'($urandom_range(0, 12)), 1'b0, 0, 0);
            if ($urandom_range(0, 3) == 0) drain();
            if ($urandom_range(0, 5) == 0) clear_errors();
            if ($urandom_range(0, 4) == 0) check_status("rand");
        end
        check_status("rand_end");
        drain();
        check_status("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial receive front-end for one UART channel; one instance per channel inside each UART device.
- Samples the asynchronous rx pin and deframes 8N1 characters at a programmable bit period.
- Buffers received bytes in a small synchronous FIFO.
- Presents bytes to the device register logic through a pop handshake, with sticky frame and overrun error flags.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 2.
- DIV_WIDTH, 16, width of the bit-period divider.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- enable  input  1  receiver enable; low aborts any frame in progress.
- cyclesPerBit  input  DIV_WIDTH  clk cycles per bit; values below 4 are treated as 4.
- rx  input  1  asynchronous serial input; idle level is high.
- readStrobe  input  1  pops the FIFO head; ignored when the FIFO is empty.
- clearErrors  input  1  clears frameError and overrun.
- dataOut  output  8  FIFO head byte; valid only while dataAvailable=1.
- dataAvailable  output  1  FIFO is not empty.
- fifoCount  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frameError  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset: state=IDLE; FIFO empty; dataOut=0, dataAvailable=0, fifoCount=0, frameError=0, overrun=0, busy=0; synchroniser flops set to 1.
- rx passes through a 2-flop synchroniser (rxs), then one further delay flop for edge detection.
- Divider counter runs 0..cyclesPerBit-1 and reloads on every state entry.
- half = cyclesPerBit>>1.
- States and transitions:
  - IDLE: on a falling edge of rxs with enable=1 -> START.
  - START: at count==half, sample rxs. If 1 (false start) -> IDLE. If 0 -> DATA with bitIndex=0 and the counter restarted, so each later sample falls mid-bit.
  - DATA: every cyclesPerBit cycles, shift rxs in LSB-first and increment bitIndex. After bit 7 -> STOP.
  - STOP: after cyclesPerBit cycles, sample rxs.
    - Sample 1: push the byte. If the FIFO is full and readStrobe=0 that cycle, drop the byte and set overrun.
    - Sample 0: discard the byte and set frameError.
    - Either outcome -> IDLE.
- After a frame error with rx held low (break), IDLE waits for a fresh high-to-low edge; no repeated frames are generated.
- Latency: the byte appears at dataOut/dataAvailable the cycle after the stop-bit sample, if the FIFO was empty.
- FIFO is first-word fall-through; dataOut always shows the head entry.
  - readStrobe pops on the clock edge.
  - Push and pop in the same cycle: both take effect and fifoCount is unchanged. This holds when full, so no overrun occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- enable=0: state forced to IDLE the next cycle and any partial byte is lost. FIFO contents and error flags are retained, and pops still work.
- clearErrors in the same cycle as a new error event: the set wins.
- cyclesPerBit is sampled continuously; software must change it only while busy=0.
- rst asserted mid-frame: everything returns to its reset values on the next edge, and the partial byte is lost.

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum {IDLE, START, DATA, STOP};
  - the constants DATA_BITS=8 and MIN_CYCLES_PER_BIT=4.
  The future transmitter reuses these.
- One sub-module, uart_rx_fifo: a parameterised synchronous FWFT FIFO with push, pop, full, empty and count. It is also reusable for the transmit path.
- Deframing FSM, divider and synchroniser stay in uart_receiver.

Test Plan:
- cyclesPerBit=16: send 0xA5 as 8N1 -> dataAvailable=1 the cycle after the stop sample, dataOut=0xA5, fifoCount=1, both error flags 0; one readStrobe -> dataAvailable=0.
- cyclesPerBit=8: rx low pulse of 3 cycles -> returns to IDLE at the START sample, no push, busy drops within 8 cycles.
- cyclesPerBit=10: frame 0x3C with stop bit driven 0 -> no push, frameError=1; then clearErrors -> frameError=0. Also hold rx low for 50 bit times -> only one frameError event, no pushes.
- FIFO_DEPTH=8, cyclesPerBit=4: send 0x00..0x08 with no reads -> fifoCount=8, overrun=1, popped data 0x00..0x07 in order. Then refill to full and send 0x55 while pulsing readStrobe in the push cycle -> fifoCount stays 8, overrun unchanged after clear, 0x55 is last out.
- cyclesPerBit=2 (clamped to 4): send 0x81 at 4 cycles/bit -> dataOut=0x81. Then deassert enable mid-DATA -> busy=0 next cycle, no push, FIFO unchanged.
- Assert rst during bit 4 of 0xF0 with 2 bytes queued -> fifoCount=0, all flags 0. A following 0x12 is received correctly.
